// File: rtl/apb_split_pkg.sv
// rtl/apb_split_pkg.sv - shared types and sizing helpers for the APB width splitter
package apb_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Number of narrow beats that make up one wide transfer.
  function automatic int ratio_f(input int ds, input int dm);
    return ds / dm;
  endfunction

  // Beat counter width; never narrower than one bit so RATIO=1 still has a counter.
  function automatic int beat_w_f(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // Bit offset of lane 'beat' inside a wide word whose lanes are 'dm' bits wide.
  function automatic int lane_lsb(input int beat, input int dm);
    return beat * dm;
  endfunction

endpackage

// File: rtl/apb_width_splitter.sv
// rtl/apb_width_splitter.sv - splits one wide APB transfer into RATIO narrow transfers; optional APB_WIDTH_SPLITTER_PSTRB_EN
module apb_width_splitter
  import apb_split_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATAS_WIDTH = 32,
  parameter int DATAM_WIDTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     s_PSEL,
  input  logic                     s_PENABLE,
  input  logic                     s_PWRITE,
  input  logic [ADDR_WIDTH-1:0]    s_PADDR,
  input  logic [DATAS_WIDTH-1:0]   s_PWDATA,
`ifdef APB_WIDTH_SPLITTER_PSTRB_EN
  input  logic [DATAS_WIDTH/8-1:0] s_PSTRB,
`endif
  output logic [DATAS_WIDTH-1:0]   s_PRDATA,
  output logic                     s_PREADY,
  output logic                     s_PSLVERR,
  output logic                     m_PSEL,
  output logic                     m_PENABLE,
  output logic                     m_PWRITE,
  output logic [ADDR_WIDTH-1:0]    m_PADDR,
  output logic [DATAM_WIDTH-1:0]   m_PWDATA,
  input  logic [DATAM_WIDTH-1:0]   m_PRDATA,
  input  logic                     m_PREADY,
  input  logic                     m_PSLVERR
);

  localparam int RATIO  = ratio_f(DATAS_WIDTH, DATAM_WIDTH);
  localparam int BEAT_W = beat_w_f(RATIO);
  localparam int MBYTES = DATAM_WIDTH / 8;
  localparam int ALIGN  = $clog2(DATAS_WIDTH / 8);

  state_t                  state, state_n;
  logic [BEAT_W-1:0]       beat, nxt_beat;
  logic                    nxt_found;
  logic                    err;
  logic                    wr;
  logic [ADDR_WIDTH-1:0]   base;
  logic [DATAS_WIDTH-1:0]  wdata;
  logic [DATAS_WIDTH-1:0]  rbuf;
  logic [RATIO-1:0]        en_mask, new_mask, search_mask;
  int                      search_from;
  logic                    start;
  logic                    beat_done;

  assign start     = (state == ST_IDLE) & s_PSEL & ~s_PENABLE;
  assign beat_done = (state == ST_ACCESS) & m_PREADY;

`ifdef APB_WIDTH_SPLITTER_PSTRB_EN
  // Writes only issue beats with at least one strobed byte; reads issue every beat.
  always_comb begin
    new_mask = '1;
    if (s_PWRITE) begin
      for (int i = 0; i < RATIO; i++) begin
        new_mask[i] = |s_PSTRB[lane_lsb(i, MBYTES) +: MBYTES];
      end
    end
  end
`else
  assign new_mask = '1;
`endif

  // Find the next beat to issue: the first enabled one at or after the search start.
  always_comb begin
    if (state == ST_IDLE) begin
      search_mask = new_mask;
      search_from = 0;
    end else begin
      search_mask = en_mask;
      search_from = int'(beat) + 1;
    end
    nxt_found = 1'b0;
    nxt_beat  = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (search_mask[i] && (i >= search_from)) begin
        nxt_found = 1'b1;
        nxt_beat  = BEAT_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    m_PSEL    = 1'b0;
    m_PENABLE = 1'b0;
    s_PREADY  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = nxt_found ? ST_SETUP : ST_DONE;
        end
      end
      ST_SETUP: begin
        m_PSEL  = 1'b1;
        state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        m_PSEL    = 1'b1;
        m_PENABLE = 1'b1;
        if (m_PREADY) begin
          state_n = (m_PSLVERR || !nxt_found) ? ST_DONE : ST_SETUP;
        end
      end
      ST_DONE: begin
        s_PREADY = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Capture the wide request, then track beat, read lanes and sticky error.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      beat    <= '0;
      err     <= 1'b0;
      wr      <= 1'b0;
      base    <= '0;
      wdata   <= '0;
      rbuf    <= '0;
      en_mask <= '0;
    end else if (start) begin
      base    <= s_PADDR & ~(ADDR_WIDTH'((1 << ALIGN) - 1));
      wr      <= s_PWRITE;
      wdata   <= s_PWDATA;
      rbuf    <= '0;
      err     <= 1'b0;
      beat    <= nxt_beat;
      en_mask <= new_mask;
    end else if (beat_done) begin
      if (!wr && !m_PSLVERR) begin
        rbuf[lane_lsb(int'(beat), DATAM_WIDTH) +: DATAM_WIDTH] <= m_PRDATA;
      end
      if (m_PSLVERR) begin
        err <= 1'b1;
      end else if (nxt_found) begin
        beat <= nxt_beat;
      end
    end
  end

  // Downstream address/data are only driven while selected; base is aligned so no carry.
  assign m_PWRITE  = m_PSEL & wr;
  assign m_PADDR   = m_PSEL ? (base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(MBYTES)) : '0;
  assign m_PWDATA  = m_PSEL ? wdata[lane_lsb(int'(beat), DATAM_WIDTH) +: DATAM_WIDTH] : '0;
  assign s_PRDATA  = s_PREADY ? rbuf : '0;
  assign s_PSLVERR = s_PREADY & err;

endmodule

// File: doc/apb_width_splitter.md
Name: apb_width_splitter

Overview:
- Downstream neighbour of the APB converter. Accepts one wide APB transfer on its slave port.
- Issues RATIO = DATAS_WIDTH/DATAM_WIDTH sequential narrow APB transfers on its master port, lowest lane first.
- Reassembles read data and folds slave errors, then completes the wide transfer.
- Sits between the 32-bit converter and the 8-bit peripheral register files.

Parameters:
- ADDR_WIDTH, 13, address width on both ports.
- DATAS_WIDTH, 32, wide (upstream slave-port) data width; integer multiple of DATAM_WIDTH, power of 2.
- DATAM_WIDTH, 8, narrow (downstream master-port) data width; multiple of 8.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset.
- s_PSEL  in  1  upstream select.
- s_PENABLE  in  1  upstream enable.
- s_PWRITE  in  1  upstream write.
- s_PADDR  in  ADDR_WIDTH  upstream byte address.
- s_PWDATA  in  DATAS_WIDTH  upstream write data.
- s_PRDATA  out  DATAS_WIDTH  assembled read data.
- s_PREADY  out  1  upstream completion.
- s_PSLVERR  out  1  upstream error.
- m_PSEL  out  1  downstream select.
- m_PENABLE  out  1  downstream enable.
- m_PWRITE  out  1  downstream write.
- m_PADDR  out  ADDR_WIDTH  downstream byte address.
- m_PWDATA  out  DATAM_WIDTH  downstream write data.
- m_PRDATA  in  DATAM_WIDTH  downstream read data.
- m_PREADY  in  1  downstream ready.
- m_PSLVERR  in  1  downstream error.

Interface constraint:
- One clock, PCLK.
- PRESETn is asynchronous, active-low.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; beat counter 0; sticky error 0; captured address/write/data 0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On s_PSEL=1 & s_PENABLE=0, capture s_PADDR with the low log2(DATAS_WIDTH/8) bits cleared (base), s_PWRITE and s_PWDATA.
  - Clear the read buffer, beat and error; go to SETUP.
- SETUP:
  - m_PSEL=1, m_PENABLE=0.
  - m_PADDR = base + beat*(DATAM_WIDTH/8).
  - m_PWRITE = captured write.
  - m_PWDATA = captured wdata[beat*DATAM_WIDTH +: DATAM_WIDTH].
  - Next state ACCESS.
- ACCESS:
  - m_PENABLE=1; address, control and data held stable.
  - Stays in ACCESS while m_PREADY=0, with no timeout.
  - On m_PREADY=1 for a read, store m_PRDATA into lane beat.
  - On m_PREADY=1 with m_PSLVERR=1: set the sticky error, abort the remaining beats, go to DONE.
  - On m_PREADY=1, otherwise: last beat goes to DONE; else beat+1 and SETUP.
  - m_PSEL stays 1 between beats; m_PENABLE drops for one cycle.
- DONE:
  - m_PSEL=0, m_PENABLE=0.
  - s_PREADY=1 for exactly one cycle; s_PRDATA = read buffer (un-read lanes 0); s_PSLVERR = sticky error.
  - Next state IDLE.
- s_PREADY is 0 in every other state. s_PRDATA and s_PSLVERR are 0 whenever s_PREADY=0.
- Latency, zero-wait downstream: s_PREADY asserts 2*RATIO+1 cycles after the upstream setup cycle. Each downstream wait state adds 1.
- Back-to-back: the IDLE cycle following DONE may capture a new setup. Minimum one idle cycle between wide transfers.
- RATIO=1 is legal: a single beat, latency 3.
- s_PSEL dropped mid-operation (protocol violation): ignored. The downstream sequence completes and DONE still pulses.
- Reset mid-operation: all outputs return to reset values asynchronously and the transfer is discarded. No downstream completion is awaited.
- Wrap-around: beat addresses never carry out of the aligned wide word, because base is aligned.

Optional Feature:
- Macro: APB_WIDTH_SPLITTER_PSTRB_EN.
- With the macro defined:
  - Adds input s_PSTRB, width DATAS_WIDTH/8.
  - On writes, a beat whose DATAM_WIDTH/8 strobe bits are all 0 is skipped: no downstream transfer, beat advances without cycles.
  - A partially strobed beat is issued in full.
  - An all-zero strobe write goes IDLE to DONE, with s_PREADY on the next cycle and no downstream activity.
  - Reads ignore s_PSTRB.
- Without the macro: the port is absent and every beat is issued.

Decomposition:
- Shared package apb_split_pkg:
  - state enum.
  - RATIO and BEAT_W (clog2 RATIO, minimum 1) localparam functions.
  - Byte-lane index helper.
- No sub-module: FSM, beat counter and lane mux fit in one module.

Test Plan:
- Read, defaults, zero-wait: s_PADDR=0x012. Slave returns 0x11,0x22,0x33,0x44 for m_PADDR 0x010..0x013 → s_PRDATA=0x44332211, s_PSLVERR=0, s_PREADY at cycle 9 after setup.
- Write 0xDEADBEEF to 0x020 → four downstream writes: 0x020=EF, 0x021=BE, 0x022=AD, 0x023=DE; m_PSEL continuously 1; m_PENABLE toggles.
- Read with 3 wait states on beat 2 → beat 2 ACCESS held 4 cycles with address stable; s_PREADY at cycle 12.
- m_PSLVERR=1 on beat 1 of a read → no beats 2/3 issued, s_PSLVERR=1, s_PRDATA=0x000000nn holding only lane 0.
- PRESETn low during beat 2 ACCESS → all outputs 0 immediately. A new read after release completes normally from beat 0.
- With APB_WIDTH_SPLITTER_PSTRB_EN: write with s_PSTRB=4'b0101 → only addresses +0 and +2 written. s_PSTRB=0 → s_PREADY the next cycle after IDLE capture, m_PSEL never asserted.
